// File: rtl/fifo_write_arbiter_if.sv
// Write-port bundle between NUM_REQ requesters, the arbiter and the FIFO write side.
// master = arbiter view, slave = requesters/FIFO view.
interface fifo_write_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  localparam int OWNER_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            gnt;
  logic                          full;
  logic                          w_en;
  logic [DATA_WIDTH-1:0]         w_data;
  logic                          busy;
  logic [OWNER_W-1:0]            owner;

  modport master (
    input  req, req_data, req_last, full,
    output gnt, w_en, w_data, busy, owner
  );

  modport slave (
    output req, req_data, req_last, full,
    input  gnt, w_en, w_data, busy, owner
  );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter sharing the FIFO write port among NUM_REQ requesters.
// One arbitration bubble per grant; a burst ends on last beat, MAX_BURST beats or req drop.
module fifo_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                 w_clk,
  input  logic                 w_rst,
  fifo_write_arbiter_if.master bus
);
  localparam int OWNER_W = $clog2(NUM_REQ);
  localparam int CNT_W   = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0]   LAST_CNT  = CNT_W'(MAX_BURST - 1);
  localparam logic [OWNER_W-1:0] RST_OWNER = OWNER_W'(NUM_REQ - 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                state, state_nxt;
  logic [OWNER_W-1:0]    owner, owner_nxt;
  logic [CNT_W-1:0]      beat_cnt, beat_cnt_nxt;
  logic                  accept;
  logic [OWNER_W-1:0]    rr_pick;
  logic                  rr_found;
  logic [OWNER_W-1:0]    rr_idx;
  logic [DATA_WIDTH-1:0] sel_data;

  // Scan starts just after the previous owner, so it is lowest priority next time.
  always_comb begin
    rr_pick  = owner;
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      rr_idx = OWNER_W'((int'(owner) + i) % NUM_REQ);
      if (!rr_found && bus.req[rr_idx]) begin
        rr_pick  = rr_idx;
        rr_found = 1'b1;
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner == OWNER_W'(i)) sel_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    beat_cnt_nxt = beat_cnt;
    accept       = 1'b0;
    case (state)
      IDLE: begin
        if (rr_found) begin
          owner_nxt    = rr_pick;
          beat_cnt_nxt = '0;
          state_nxt    = BURST;
        end
      end
      BURST: begin
        // full freezes the burst entirely, including a pending last beat.
        if (!bus.full) begin
          if (!bus.req[owner]) begin
            state_nxt = IDLE;
          end else begin
            accept       = 1'b1;
            beat_cnt_nxt = beat_cnt + 1'b1;
            if (bus.req_last[owner] || beat_cnt == LAST_CNT) state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (w_rst) accept = 1'b0;
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      state    <= IDLE;
      owner    <= RST_OWNER;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

  assign bus.w_en   = accept;
  assign bus.gnt    = accept ? (NUM_REQ'(1) << owner) : '0;
  assign bus.w_data = accept ? sel_data : '0;
  assign bus.busy   = (state == BURST) && !w_rst;
  assign bus.owner  = owner;
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: requesters are packet queues, a round-robin burst
// model predicts every cycle; directed scenarios followed by a randomized run.
module tb_fifo_write_arbiter;
  localparam int NUM_REQ    = 4;
  localparam int DATA_WIDTH = 8;
  localparam int MAX_BURST  = 4;

  logic w_clk = 1'b0;
  logic w_rst;
  always #5 w_clk = ~w_clk;

  fifo_write_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH)) bus ();

  fifo_write_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .MAX_BURST(MAX_BURST)
  ) dut (
    .w_clk(w_clk),
    .w_rst(w_rst),
    .bus  (bus)
  );

  // Pending beats per requester: {last, requester id, sequence number}.
  logic [8:0] pend [NUM_REQ][256];
  logic [7:0] hd [NUM_REQ];
  logic [7:0] tl [NUM_REQ];
  int         seq [NUM_REQ];

  logic rst_v, full_v;
  int   n_cmp = 0, n_err = 0;
  int   n_push = 0, n_write = 0, cyc = 0;

  // Reference: whether a burst is open, who owns the port, beats taken so far.
  bit   m_busy;
  int   m_owner;
  int   m_taken;

  logic [9:0] wlog [$];

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int occ(int r);
    logic [7:0] d;
    d = tl[r] - hd[r];
    return int'(d);
  endfunction

  function automatic int pending();
    int s = 0;
    for (int r = 0; r < NUM_REQ; r++) s += occ(r);
    return s;
  endfunction

  task automatic push_pkt(int r, int len, bit with_last);
    for (int k = 0; k < len; k++) begin
      pend[r][tl[r]] = {with_last && (k == len - 1), 2'(r), 6'(seq[r])};
      seq[r]++;
      tl[r]++;
      n_push++;
    end
  endtask

  task automatic drive();
    logic [8:0] h;
    w_rst    = rst_v;
    bus.full = full_v;
    for (int r = 0; r < NUM_REQ; r++) begin
      h = pend[r][hd[r]];
      bus.req[r]      = (occ(r) != 0);
      bus.req_last[r] = (occ(r) != 0) && h[8];
      bus.req_data[r*DATA_WIDTH +: DATA_WIDTH] = (occ(r) != 0) ? h[7:0] : 8'h00;
    end
  endtask

  task automatic step();
    logic [NUM_REQ-1:0] rq;
    bit                 acc;
    logic [8:0]         head;
    drive();
    for (int r = 0; r < NUM_REQ; r++) rq[r] = (occ(r) != 0);
    @(negedge w_clk);
    head = pend[m_owner][hd[m_owner]];
    acc  = !rst_v && m_busy && rq[m_owner] && !full_v;
    check("w_en",   32'(bus.w_en),   32'(acc));
    check("gnt",    32'(bus.gnt),    acc ? (32'd1 << m_owner) : 32'd0);
    check("w_data", 32'(bus.w_data), acc ? 32'(head[7:0]) : 32'd0);
    check("busy",   32'(bus.busy),   32'(!rst_v && m_busy));
    if (!rst_v) check("owner", 32'(bus.owner), 32'(m_owner));
    if (bus.w_en) begin
      wlog.push_back({bus.owner, bus.w_data});
      n_write++;
    end
    @(posedge w_clk);
    cyc++;
    if (rst_v) begin
      m_busy  = 1'b0;
      m_owner = NUM_REQ - 1;
      m_taken = 0;
    end else if (!m_busy) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        if (rq[(m_owner + k) % NUM_REQ]) begin
          m_owner = (m_owner + k) % NUM_REQ;
          m_busy  = 1'b1;
          m_taken = 0;
          break;
        end
      end
    end else if (!full_v) begin
      if (!rq[m_owner]) begin
        m_busy = 1'b0;
      end else begin
        hd[m_owner]++;
        m_taken++;
        if (head[8] || m_taken == MAX_BURST) m_busy = 1'b0;
      end
    end
    #1;
  endtask

  task automatic drain();
    int guard = 0;
    while ((pending() != 0 || m_busy) && guard < 400) begin
      step();
      guard++;
    end
  endtask

  task automatic reset_pulse();
    rst_v = 1'b1;
    step();
    rst_v = 1'b0;
  endtask

  initial begin
    int c0, s0;
    for (int r = 0; r < NUM_REQ; r++) begin
      hd[r] = '0; tl[r] = '0; seq[r] = 0;
    end
    m_busy = 1'b0; m_owner = NUM_REQ - 1; m_taken = 0;
    rst_v = 1'b1; full_v = 1'b0;
    bus.req = '0; bus.req_last = '0; bus.req_data = '0; bus.full = 1'b0; w_rst = 1'b1;
    #1;

    // Reset held 3 cycles with everyone requesting; first grant goes to 0, then 1,2,3.
    for (int r = 0; r < NUM_REQ; r++) push_pkt(r, 1, 1'b1);
    repeat (3) step();
    rst_v = 1'b0;
    wlog.delete();
    drain();
    check("t1_writes", 32'(wlog.size()), 32'd4);
    for (int i = 0; i < 4; i++) check("t1_order", 32'(wlog[i][9:8]), 32'(i));

    // Single 3-beat packet on requester 2: bubble then three writes.
    wlog.delete();
    s0 = seq[2];
    c0 = cyc;
    push_pkt(2, 3, 1'b1);
    drain();
    check("t2_cycles", 32'(cyc - c0), 32'd4);
    check("t2_writes", 32'(wlog.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      check("t2_data", 32'(wlog[i]), 32'({2'd2, 2'd2, 6'(s0 + i)}));

    // Full contention: 4-beat bursts in order 0,1,2,3 then 0 again.
    reset_pulse();
    for (int r = 0; r < NUM_REQ; r++) push_pkt(r, 8, 1'b0);
    wlog.delete();
    repeat (20) step();
    check("t3_writes20", 32'(wlog.size()), 32'd16);
    for (int i = 0; i < 16; i++) check("t3_owner", 32'(wlog[i][9:8]), 32'(i / 4));
    repeat (2) step();
    check("t3_wrap", 32'(wlog[16][9:8]), 32'd0);
    drain();
    check("t3_total", 32'(wlog.size()), 32'd32);

    // Back-pressure for 5 cycles after beat 2 of a 4-beat burst.
    reset_pulse();
    wlog.delete();
    s0 = seq[0];
    push_pkt(0, 4, 1'b1);
    repeat (3) step();
    full_v = 1'b1;
    repeat (5) step();
    check("t4_stalled", 32'(wlog.size()), 32'd2);
    full_v = 1'b0;
    drain();
    check("t4_writes", 32'(wlog.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      check("t4_data", 32'(wlog[i][7:0]), 32'({2'd0, 6'(s0 + i)}));

    // Requester 1 drops after 2 beats; requester 3 follows after one bubble.
    wlog.delete();
    c0 = cyc;
    push_pkt(1, 2, 1'b0);
    push_pkt(3, 2, 1'b1);
    drain();
    check("t5_cycles", 32'(cyc - c0), 32'd7);
    check("t5_writes", 32'(wlog.size()), 32'd4);
    check("t5_o0", 32'(wlog[0][9:8]), 32'd1);
    check("t5_o1", 32'(wlog[1][9:8]), 32'd1);
    check("t5_o2", 32'(wlog[2][9:8]), 32'd3);
    check("t5_o3", 32'(wlog[3][9:8]), 32'd3);

    // Reset during beat 2 of requester 2; next grant must go to 0.
    push_pkt(2, 4, 1'b1);
    repeat (2) step();
    rst_v = 1'b1;
    step();
    rst_v = 1'b0;
    push_pkt(0, 1, 1'b1);
    push_pkt(3, 1, 1'b1);
    wlog.delete();
    drain();
    check("t6_writes", 32'(wlog.size()), 32'd5);
    check("t6_first", 32'(wlog[0][9:8]), 32'd0);
    check("t6_second", 32'(wlog[1][9:8]), 32'd2);

    // Randomized traffic with back-pressure and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      int r;
      r = int'($urandom_range(NUM_REQ - 1));
      if ($urandom_range(3) == 0 && occ(r) < 20)
        push_pkt(r, int'($urandom_range(6, 1)), $urandom_range(3) != 0);
      full_v = ($urandom_range(4) == 0);
      rst_v  = ($urandom_range(199) == 0);
      step();
    end
    rst_v = 1'b0;
    full_v = 1'b0;
    drain();
    check("all_beats_written", 32'(n_write), 32'(n_push));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
